// File: rtl/mux_gate_checker_pkg.sv
// rtl/mux_gate_checker_pkg.sv - shared gate indices, combination count and FSM encoding
package mux_gate_checker_pkg;

  // Bit positions of each gate output within the 6-bit response vector
  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NAND = 2;
  localparam int GATE_NOR  = 3;
  localparam int GATE_XOR  = 4;
  localparam int GATE_XNOR = 5;
  localparam int NUM_GATES = 6;

  // Number of {A,B} combinations in one sweep
  localparam int NUM_COMBOS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/mux_gate_golden.sv
// rtl/mux_gate_golden.sv - combinational reference outputs for the six two-input gates
module mux_gate_golden
  import mux_gate_checker_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] exp
);

  // Ideal truth table for every gate, placed at its response bit index
  always_comb begin
    exp            = '0;
    exp[GATE_AND]  = a & b;
    exp[GATE_OR]   = a | b;
    exp[GATE_NAND] = ~(a & b);
    exp[GATE_NOR]  = ~(a | b);
    exp[GATE_XOR]  = a ^ b;
    exp[GATE_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/mux_gate_checker.sv
// rtl/mux_gate_checker.sv - sweeps A/B through all combinations and checks six gate outputs
module mux_gate_checker
  import mux_gate_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4,
  parameter int NUM_PASSES    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [NUM_GATES-1:0] y_i,
  output logic                 a_o,
  output logic                 b_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_W-1:0]     err_cnt_o,
  output logic [NUM_COMBOS-1:0] fail_combo_o,
  output logic [NUM_GATES-1:0] first_fail_gates_o
);

  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int PASS_W = $clog2(NUM_PASSES + 1);

  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(NUM_PASSES - 1);
  localparam logic [1:0]        COMBO_LAST  = 2'(NUM_COMBOS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = {ERR_W{1'b1}};

  state_e               r_state;
  state_e               w_next_state;
  logic [SET_W-1:0]     r_settle;
  logic [1:0]           r_combo;
  logic [PASS_W-1:0]    r_pass;
  logic [ERR_W-1:0]     r_err;
  logic [NUM_COMBOS-1:0] r_fail_combo;
  logic [NUM_GATES-1:0] r_first_fail;
  logic                 r_any_fail;
  logic                 r_pass_flag;

  logic                 w_start;
  logic                 w_sample;
  logic                 w_last;
  logic [NUM_GATES-1:0] w_exp;
  logic [NUM_GATES-1:0] w_mm;
  logic                 w_mm_any;

  // r_combo is {A,B}; it doubles as the registered gate inputs
  mux_gate_golden u_golden (
    .a   (r_combo[1]),
    .b   (r_combo[0]),
    .exp (w_exp)
  );

  assign w_mm     = y_i ^ w_exp;
  assign w_mm_any = |w_mm;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic plus the start/sample/last-sample strobes used by the datapath
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_sample     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_start      = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_settle == SETTLE_LAST) begin
          w_sample = 1'b1;
          if (r_combo == COMBO_LAST && r_pass == PASS_LAST) begin
            w_last       = 1'b1;
            w_next_state = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Settle, combination and pass counters; A/B wrap 11 -> 00 between passes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
      r_combo  <= '0;
      r_pass   <= '0;
    end else if (w_start) begin
      r_settle <= '0;
      r_combo  <= '0;
      r_pass   <= '0;
    end else if (w_sample) begin
      r_settle <= '0;
      if (w_last) begin
        r_combo <= '0;
        r_pass  <= '0;
      end else begin
        r_combo <= r_combo + 2'd1;
        if (r_combo == COMBO_LAST) begin
          r_pass <= r_pass + PASS_W'(1);
        end
      end
    end else if (r_state == ST_RUN) begin
      r_settle <= r_settle + SET_W'(1);
    end
  end

  // Result registers: cleared on an accepted start, updated at each sample edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err        <= '0;
      r_fail_combo <= '0;
      r_first_fail <= '0;
      r_any_fail   <= 1'b0;
      r_pass_flag  <= 1'b0;
    end else if (w_start) begin
      r_err        <= '0;
      r_fail_combo <= '0;
      r_first_fail <= '0;
      r_any_fail   <= 1'b0;
      r_pass_flag  <= 1'b0;
    end else if (w_sample) begin
      if (w_mm_any) begin
        if (r_err != ERR_MAX) begin
          r_err <= r_err + ERR_W'(1);
        end
        r_fail_combo[r_combo] <= 1'b1;
        if (!r_any_fail) begin
          r_first_fail <= w_mm;
          r_any_fail   <= 1'b1;
        end
      end
      // The final sample counts too, so it is folded in directly
      if (w_last) begin
        r_pass_flag <= !r_any_fail && !w_mm_any;
      end
    end
  end

  assign a_o                = r_combo[1];
  assign b_o                = r_combo[0];
  assign busy_o             = (r_state == ST_RUN);
  assign done_o             = (r_state == ST_FIN);
  assign pass_o             = r_pass_flag;
  assign err_cnt_o          = r_err;
  assign fail_combo_o       = r_fail_combo;
  assign first_fail_gates_o = r_first_fail;

endmodule

// File: tb/tb_mux_gate_checker.sv
// tb/tb_mux_gate_checker.sv - table-driven self-checking bench for mux_gate_checker
module tb_mux_gate_checker;

  logic clk;
  logic rst_n;
  logic [2:0] start_v;
  int   mode [3];
  int   cur_sel;
  int   total;
  int   bad;

  // dut0: S=2 ERR_W=4 P=1; dut1: S=2 ERR_W=2 P=1; dut2: S=2 ERR_W=4 P=2
  logic       a0, b0, busy0, done0, pass0;
  logic [3:0] err0, fc0;
  logic [5:0] ff0, y0;
  logic       a1, b1, busy1, done1, pass1;
  logic [1:0] err1;
  logic [3:0] fc1;
  logic [5:0] ff1, y1;
  logic       a2, b2, busy2, done2, pass2;
  logic [3:0] err2, fc2;
  logic [5:0] ff2, y2;

  logic       m_a, m_b, m_busy, m_done, m_pass;
  logic [3:0] m_err, m_fc;
  logic [5:0] m_ff;

  mux_gate_checker #(.SETTLE_CYCLES(2), .ERR_W(4), .NUM_PASSES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[0]), .y_i(y0),
    .a_o(a0), .b_o(b0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
    .err_cnt_o(err0), .fail_combo_o(fc0), .first_fail_gates_o(ff0)
  );

  mux_gate_checker #(.SETTLE_CYCLES(2), .ERR_W(2), .NUM_PASSES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[1]), .y_i(y1),
    .a_o(a1), .b_o(b1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .err_cnt_o(err1), .fail_combo_o(fc1), .first_fail_gates_o(ff1)
  );

  mux_gate_checker #(.SETTLE_CYCLES(2), .ERR_W(4), .NUM_PASSES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[2]), .y_i(y2),
    .a_o(a2), .b_o(b2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .err_cnt_o(err2), .fail_combo_o(fc2), .first_fail_gates_o(ff2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate emulation: 0 ideal, 1 XOR stuck at 0, 2 AND/OR swapped, 3 all inverted
  function automatic logic [5:0] gate_y(input int m, input logic a, input logic b);
    logic [5:0] y;
    y = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    case (m)
      1: y[4] = 1'b0;
      2: y[1:0] = {y[0], y[1]};
      3: y = ~y;
      default: ;
    endcase
    return y;
  endfunction

  always_comb y0 = gate_y(mode[0], a0, b0);
  always_comb y1 = gate_y(mode[1], a1, b1);
  always_comb y2 = gate_y(mode[2], a2, b2);

  // Observe the instance currently under test through one set of signals
  always_comb begin
    case (cur_sel)
      0: begin
        m_a = a0; m_b = b0; m_busy = busy0; m_done = done0; m_pass = pass0;
        m_err = err0; m_fc = fc0; m_ff = ff0;
      end
      1: begin
        m_a = a1; m_b = b1; m_busy = busy1; m_done = done1; m_pass = pass1;
        m_err = {2'b00, err1}; m_fc = fc1; m_ff = ff1;
      end
      default: begin
        m_a = a2; m_b = b2; m_busy = busy2; m_done = done2; m_pass = pass2;
        m_err = err2; m_fc = fc2; m_ff = ff2;
      end
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  typedef struct {
    int         dut;
    int         mode;
    int         glitch_t;
    int         done_t;
    logic       pass;
    logic [3:0] err;
    logic [3:0] fc;
    logic [5:0] ff;
  } vec_t;

  vec_t vecs [8];

  // One full run: start, check the A/B sequence each cycle, then the results
  task automatic run_vec(input vec_t v);
    int t;
    int seq_bad;
    int done_t;
    logic [1:0] exp_ab;
    cur_sel = v.dut;
    mode[v.dut] = v.mode;
    @(negedge clk);
    start_v[v.dut] = 1'b1;
    @(negedge clk);
    start_v = '0;
    t = 0;
    seq_bad = 0;
    done_t = -1;
    while (t < 64 && done_t < 0) begin
      start_v[v.dut] = (t == v.glitch_t);
      if (m_done) begin
        done_t = t;
      end else begin
        exp_ab = 2'((t / 2) % 4);
        if (!m_busy || {m_a, m_b} != exp_ab) seq_bad++;
        @(negedge clk);
        t++;
      end
    end
    start_v = '0;
    chk("seq", seq_bad, 0);
    chk("done_time", done_t, v.done_t);
    chk("busy_at_done", m_busy, 1'b0);
    chk("ab_at_done", {m_a, m_b}, 2'b00);
    chk("pass", m_pass, v.pass);
    chk("err_cnt", m_err, v.err);
    chk("fail_combo", m_fc, v.fc);
    chk("first_fail", m_ff, v.ff);
    @(negedge clk);
    chk("done_one_cycle", m_done, 1'b0);
    chk("err_hold", m_err, v.err);
    chk("pass_hold", m_pass, v.pass);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic dn;
    total = 0;
    bad = 0;
    cur_sel = 0;
    start_v = '0;
    mode[0] = 0; mode[1] = 0; mode[2] = 0;
    rst_n = 1'b0;

    //           dut mode glitch done pass err    fc       ff
    vecs[0] = '{0, 0, -1,  8, 1'b1, 4'd0, 4'b0000, 6'b000000};
    vecs[1] = '{0, 1, -1,  8, 1'b0, 4'd2, 4'b0110, 6'b010000};
    vecs[2] = '{0, 2, -1,  8, 1'b0, 4'd2, 4'b0110, 6'b000011};
    vecs[3] = '{0, 3, -1,  8, 1'b0, 4'd4, 4'b1111, 6'b111111};
    vecs[4] = '{1, 3, -1,  8, 1'b0, 4'd3, 4'b1111, 6'b111111};
    vecs[5] = '{2, 3, -1, 16, 1'b0, 4'd8, 4'b1111, 6'b111111};
    vecs[6] = '{2, 0, -1, 16, 1'b1, 4'd0, 4'b0000, 6'b000000};
    vecs[7] = '{0, 0,  2,  8, 1'b1, 4'd0, 4'b0000, 6'b000000};

    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      cur_sel = s;
      #1;
      chk("reset_state", {m_busy, m_done, m_pass, m_a, m_b, m_err, m_fc, m_ff}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Reset in the middle of a run aborts it and clears everything at once
    cur_sel = 0;
    mode[0] = 3;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v = '0;
    repeat (4) @(negedge clk);
    chk("mid_err_before_reset", m_err, 4'd2);
    chk("mid_fc_before_reset", m_fc, 4'b0011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_clear", {m_busy, m_done, m_pass, m_a, m_b, m_err, m_fc, m_ff}, 0);
    dn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      dn = dn | m_done;
    end
    chk("mid_reset_no_done", dn, 1'b0);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    // Start held high across done: second run accepted one cycle after FIN
    cur_sel = 0;
    mode[0] = 3;
    @(negedge clk);
    start_v[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("held_first_done", m_done, 1'b1);
    chk("held_first_err", m_err, 4'd4);
    mode[0] = 0;
    @(negedge clk);
    chk("held_idle_busy", m_busy, 1'b0);
    chk("held_idle_err_kept", m_err, 4'd4);
    @(negedge clk);
    chk("held_restart_busy", m_busy, 1'b1);
    chk("held_restart_cleared", {m_pass, m_err, m_fc, m_ff, m_a, m_b}, 0);
    start_v = '0;
    n = 0;
    while (!m_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("held_second_done_time", n, 8);
    chk("held_second_pass", m_pass, 1'b1);
    chk("held_second_err", m_err, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
